// File: rtl/menu_select_fsm.sv
// Title/menu controller: gates start, walks a cursor over NUM_OPTIONS tiles, confirms or backs out of a choice.
// Latency: one cycle from a sampled click to select/cursor/state outputs; pixel_out is one cycle behind its inputs.
// Backpressure: none; button levels are sampled every cycle and there is no stall path.
module menu_select_fsm #(
   parameter int NUM_OPTIONS   = 6,
   parameter int COLS          = 3,
   parameter int X0            = 120,
   parameter int X_STEP        = 340,
   parameter int Y0            = 334,
   parameter int Y_STEP        = 0,
   parameter int REPEAT_DELAY  = 37_125_000,
   parameter int REPEAT_PERIOD = 12_375_000,
   localparam int SEL_W        = $clog2(NUM_OPTIONS),
   localparam int NUM_ROWS     = (NUM_OPTIONS + COLS - 1) / COLS,
   localparam int ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             enable_in,
   input  logic             left_in,
   input  logic             right_in,
   input  logic             middle_in,
   input  logic             back_in,
   input  logic [11:0]      title_pixel_in,
   input  logic [11:0]      instr_pixel_in,
   input  logic [11:0]      menu_pixel_in,
   input  logic [11:0]      cursor_pixel_in,
   output logic [11:0]      pixel_out,
   output logic [SEL_W-1:0] select_out,
   output logic [10:0]      cursor_x_out,
   output logic [9:0]       cursor_y_out,
   output logic [ROW_W-1:0] cursor_row_out,
   output logic             menu_active_out,
   output logic             confirmed_out,
   output logic             select_valid_out
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int HC_W  = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

   localparam logic [1:0] ST_START     = 2'd0;
   localparam logic [1:0] ST_SELECT    = 2'd1;
   localparam logic [1:0] ST_CONFIRMED = 2'd2;

   // Wrap targets are elaboration-time constants, so no divider or multiplier is built.
   localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_OPTIONS - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] COL_WRAP  = COL_W'((NUM_OPTIONS - 1) % COLS);
   localparam logic [ROW_W-1:0] ROW_WRAP  = ROW_W'((NUM_OPTIONS - 1) / COLS);
   localparam logic [10:0]      X_BASE    = 11'(X0);
   localparam logic [10:0]      X_PITCH   = 11'(X_STEP);
   localparam logic [10:0]      X_ROW_END = 11'(X0 + (COLS - 1) * X_STEP);
   localparam logic [10:0]      X_WRAP    = 11'(X0 + ((NUM_OPTIONS - 1) % COLS) * X_STEP);
   localparam logic [9:0]       Y_BASE    = 10'(Y0);
   localparam logic [9:0]       Y_PITCH   = 10'(Y_STEP);
   localparam logic [9:0]       Y_WRAP    = 10'(Y0 + ((NUM_OPTIONS - 1) / COLS) * Y_STEP);
   localparam logic [HC_W:0]    HC_DELAY  = (HC_W + 1)'(REPEAT_DELAY);
   localparam logic [HC_W-1:0]  HC_RELOAD = HC_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic             left_q, right_q, middle_q, back_q;
   logic             left_clk, right_clk, middle_clk, back_clk, any_clk;
   logic             single_held, rep_fire, in_select, step_fwd, step_back;
   logic [HC_W-1:0]  hold_cnt;
   logic [HC_W:0]    hold_inc;
   logic [1:0]       state_q;
   logic [SEL_W-1:0] sel_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [10:0]      x_q;
   logic [9:0]       y_q;
   logic             active_q, confirmed_q, valid_q;
   logic [11:0]      pixel_q;

   // Previous button levels for rising-edge (click) detection.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         middle_q <= 1'b0;
         back_q   <= 1'b0;
      end else begin
         left_q   <= left_in;
         right_q  <= right_in;
         middle_q <= middle_in;
         back_q   <= back_in;
      end
   end

   // Click decode, auto-repeat trigger and step direction; middle wins, left+right cancel.
   always_comb begin
      left_clk    = left_in & ~left_q;
      right_clk   = right_in & ~right_q;
      middle_clk  = middle_in & ~middle_q;
      back_clk    = back_in & ~back_q;
      any_clk     = left_clk | right_clk | middle_clk | back_clk;
      single_held = left_in ^ right_in;
      hold_inc    = {1'b0, hold_cnt} + 1'b1;
      rep_fire    = (REPEAT_DELAY != 0) && !any_clk && single_held && (hold_inc == HC_DELAY);
      in_select   = (state_q == ST_SELECT);
      step_fwd    = in_select && !middle_clk &&
                    ((right_clk && !left_clk) || (rep_fire && right_in));
      step_back   = in_select && !middle_clk &&
                    ((left_clk && !right_clk) || (rep_fire && left_in));
   end

   // Hold counter: first repeat REPEAT_DELAY cycles after the click, then every REPEAT_PERIOD.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hold_cnt <= '0;
      end else if (any_clk || !single_held || (REPEAT_DELAY == 0)) begin
         hold_cnt <= '0;
      end else if (rep_fire) begin
         hold_cnt <= HC_RELOAD;
      end else begin
         hold_cnt <= hold_inc[HC_W-1:0];
      end
   end

   // Top-level state with registered status flags and the one-cycle confirm pulse.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ST_START;
         active_q    <= 1'b0;
         confirmed_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_START: begin
               if (middle_clk && enable_in) begin
                  state_q  <= ST_SELECT;
                  active_q <= 1'b1;
               end
            end
            ST_SELECT: begin
               if (middle_clk) begin
                  state_q     <= ST_CONFIRMED;
                  confirmed_q <= 1'b1;
                  valid_q     <= 1'b1;
               end
            end
            ST_CONFIRMED: begin
               if (back_clk) begin
                  state_q     <= ST_SELECT;
                  confirmed_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_START;
               active_q    <= 1'b0;
               confirmed_q <= 1'b0;
            end
         endcase
      end
   end

   // Cursor index, col/row and pixel position move together; position tracks by adding the pitch.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sel_q <= '0;
         col_q <= '0;
         row_q <= '0;
         x_q   <= X_BASE;
         y_q   <= Y_BASE;
      end else if (step_fwd) begin
         if (sel_q == IDX_LAST) begin
            sel_q <= '0;
            col_q <= '0;
            row_q <= '0;
            x_q   <= X_BASE;
            y_q   <= Y_BASE;
         end else begin
            sel_q <= sel_q + 1'b1;
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
               x_q   <= X_BASE;
               y_q   <= y_q + Y_PITCH;
            end else begin
               col_q <= col_q + 1'b1;
               x_q   <= x_q + X_PITCH;
            end
         end
      end else if (step_back) begin
         if (sel_q == '0) begin
            sel_q <= IDX_LAST;
            col_q <= COL_WRAP;
            row_q <= ROW_WRAP;
            x_q   <= X_WRAP;
            y_q   <= Y_WRAP;
         end else begin
            sel_q <= sel_q - 1'b1;
            if (col_q == '0) begin
               col_q <= COL_LAST;
               row_q <= row_q - 1'b1;
               x_q   <= X_ROW_END;
               y_q   <= y_q - Y_PITCH;
            end else begin
               col_q <= col_q - 1'b1;
               x_q   <= x_q - X_PITCH;
            end
         end
      end
   end

   // UI pixel: title (plus instructions when enabled) before start, menu with cursor afterwards.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pixel_q <= '0;
      end else if (state_q == ST_START) begin
         pixel_q <= title_pixel_in | (enable_in ? instr_pixel_in : 12'h000);
      end else begin
         pixel_q <= menu_pixel_in | cursor_pixel_in;
      end
   end

   assign pixel_out        = pixel_q;
   assign select_out       = sel_q;
   assign cursor_x_out     = x_q;
   assign cursor_y_out     = y_q;
   assign cursor_row_out   = row_q;
   assign menu_active_out  = active_q;
   assign confirmed_out    = confirmed_q;
   assign select_valid_out = valid_q;

endmodule

// File: tb/tb_menu_select_fsm.sv
// Bench for menu_select_fsm: a per-cycle reference model pushes expected outputs to a scoreboard queue.
// Latency: each expectation is popped and compared one clock edge after its stimulus.
// Backpressure: none; the bench drives one stimulus vector per clock.
module tb_menu_select_fsm;

   localparam int N      = 6;
   localparam int COLS   = 3;
   localparam int X0     = 120;
   localparam int XS     = 340;
   localparam int Y0     = 334;
   localparam int YS     = 0;
   localparam int DELAY  = 8;
   localparam int PERIOD = 4;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic        left_in, right_in, middle_in, back_in;
   logic [11:0] title_pixel_in, instr_pixel_in, menu_pixel_in, cursor_pixel_in;
   logic [11:0] pixel_out;
   logic [2:0]  select_out;
   logic [10:0] cursor_x_out;
   logic [9:0]  cursor_y_out;
   logic [0:0]  cursor_row_out;
   logic        menu_active_out, confirmed_out, select_valid_out;

   menu_select_fsm #(
      .NUM_OPTIONS(N), .COLS(COLS), .X0(X0), .X_STEP(XS), .Y0(Y0), .Y_STEP(YS),
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .left_in(left_in), .right_in(right_in), .middle_in(middle_in), .back_in(back_in),
      .title_pixel_in(title_pixel_in), .instr_pixel_in(instr_pixel_in),
      .menu_pixel_in(menu_pixel_in), .cursor_pixel_in(cursor_pixel_in),
      .pixel_out(pixel_out), .select_out(select_out),
      .cursor_x_out(cursor_x_out), .cursor_y_out(cursor_y_out),
      .cursor_row_out(cursor_row_out), .menu_active_out(menu_active_out),
      .confirmed_out(confirmed_out), .select_valid_out(select_valid_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int sel; int x; int y; int row; int act; int conf; int vld; int pix;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: 0 START, 1 SELECT, 2 CONFIRMED.
   int   m_state, m_idx, m_held;
   bit   pl, pr, pm, pb;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_idx = 0; m_held = 0;
      pl = 0; pr = 0; pm = 0; pb = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_sel"},  int'(select_out), 0);
      check({tag, "_x"},    int'(cursor_x_out), X0);
      check({tag, "_y"},    int'(cursor_y_out), Y0);
      check({tag, "_row"},  int'(cursor_row_out), 0);
      check({tag, "_act"},  int'(menu_active_out), 0);
      check({tag, "_conf"}, int'(confirmed_out), 0);
      check({tag, "_vld"},  int'(select_valid_out), 0);
      check({tag, "_pix"},  int'(pixel_out), 0);
      check({tag, "_hold"}, int'(dut.hold_cnt), 0);
   endtask

   // Drive one cycle of buttons, predict the post-edge outputs, then compare after the edge.
   task automatic step(input bit l, input bit r, input bit m, input bit b);
      exp_t e, got;
      bit   lc, rc, mc, bc, rep;
      left_in = l; right_in = r; middle_in = m; back_in = b;
      title_pixel_in  = 12'($urandom);
      instr_pixel_in  = 12'($urandom);
      menu_pixel_in   = 12'($urandom);
      cursor_pixel_in = 12'($urandom);
      e.pix = (m_state == 0) ? int'(title_pixel_in | (enable_in ? instr_pixel_in : 12'h000))
                             : int'(menu_pixel_in | cursor_pixel_in);
      lc = l & ~pl; rc = r & ~pr; mc = m & ~pm; bc = b & ~pb;
      pl = l; pr = r; pm = m; pb = b;
      rep = 0;
      if (lc || rc || mc || bc || !(l ^ r)) begin
         m_held = 0;
      end else begin
         m_held++;
         if (m_held == DELAY || (m_held > DELAY && ((m_held - DELAY) % PERIOD) == 0)) rep = 1;
      end
      e.vld = 0;
      case (m_state)
         0: if (mc && enable_in) m_state = 1;
         1: begin
            if (mc) begin
               m_state = 2;
               e.vld   = 1;
            end else if ((rc && !lc) || (rep && r)) begin
               m_idx = (m_idx + 1) % N;
            end else if ((lc && !rc) || (rep && l)) begin
               m_idx = (m_idx + N - 1) % N;
            end
         end
         default: if (bc) m_state = 1;
      endcase
      e.sel  = m_idx;
      e.x    = (X0 + (m_idx % COLS) * XS) % 2048;
      e.y    = (Y0 + (m_idx / COLS) * YS) % 1024;
      e.row  = m_idx / COLS;
      e.act  = (m_state != 0) ? 1 : 0;
      e.conf = (m_state == 2) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk_in);
      #1;
      got = sb.pop_front();
      check("sel",  int'(select_out),       got.sel);
      check("x",    int'(cursor_x_out),     got.x);
      check("y",    int'(cursor_y_out),     got.y);
      check("row",  int'(cursor_row_out),   got.row);
      check("act",  int'(menu_active_out),  got.act);
      check("conf", int'(confirmed_out),    got.conf);
      check("vld",  int'(select_valid_out), got.vld);
      check("pix",  int'(pixel_out),        got.pix);
   endtask

   task automatic click(input bit l, input bit r, input bit m, input bit b);
      step(l, r, m, b);
      step(0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_in = 1'b1; enable_in = 1'b0;
      left_in = 0; right_in = 0; middle_in = 0; back_in = 0;
      title_pixel_in = '0; instr_pixel_in = '0; menu_pixel_in = '0; cursor_pixel_in = '0;
      model_reset();
      #2;
      check_reset_values("rst");
      @(posedge clk_in);
      #2;
      rst_in = 1'b0;

      // Start gating: ignored while disabled, accepted once enabled.
      click(0, 0, 1, 0);
      check("start_gated", int'(menu_active_out), 0);
      enable_in = 1'b1;
      click(0, 0, 1, 0);
      check("start_ok", int'(menu_active_out), 1);

      // Right walk across both rows with wrap back to 0; back is a no-op in SELECT.
      click(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) click(0, 1, 0, 0);
      check("right_wrap", int'(select_out), 0);

      // Left wrap and simultaneous left+right.
      click(1, 0, 0, 0);
      check("left_wrap", int'(select_out), 5);
      click(1, 1, 0, 0);
      check("lr_cancel", int'(select_out), 5);
      click(0, 1, 0, 0);

      // Hold-to-repeat from index 0 for 20 cycles.
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
      check("repeat_idx", int'(select_out), 4);
      step(0, 0, 0, 0);
      check("hold_clr", int'(dut.hold_cnt), 0);

      // Confirm with middle+right together at index 2, then back out.
      click(1, 0, 0, 0);
      click(1, 0, 0, 0);
      step(0, 1, 1, 0);
      check("conf_idx", int'(select_out), 2);
      step(0, 0, 0, 0);
      click(0, 1, 0, 0);
      click(1, 0, 0, 0);
      check("conf_hold", int'(select_out), 2);
      click(0, 0, 0, 1);
      check("back_sel", int'(confirmed_out), 0);

      // Async reset mid-SELECT at index 4.
      click(0, 1, 0, 0);
      click(0, 1, 0, 0);
      check("pre_rst_idx", int'(select_out), 4);
      #2;
      rst_in = 1'b1;
      #1;
      check_reset_values("arst");
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      model_reset();
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
